// File: rtl/sync_sys_pkg.sv
// Shared definitions for the destination-domain sync path: default bus width,
// a constant clog2 helper and the statistics build switch.
// Build option: define SYNC_WORD_BUF_STATS_EN to add the ovf_count port.
package sync_sys_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 4;
  localparam int OVF_CNT_W          = 8;

`ifdef SYNC_WORD_BUF_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  // Ceiling log2, usable in parameter expressions; returns at least 1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    if (res == 0) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/sync_word_buffer_if.sv
// Word stream interface: synchronized capture side plus valid/ready consumer side.
// slave = the buffer, master = the synchronizer/consumer pair driving it.
interface sync_word_buffer_if #(
  parameter int DATA_WIDTH = sync_sys_pkg::DEFAULT_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid
  );
endinterface

// File: rtl/sync_word_buf_ctrl.sv
// Queue control: pointers, occupancy, push/pop/drop decode, busy and sticky overflow.
// Storage lives in the parent; this block only says when and where to write/read.
module sync_word_buf_ctrl
  import sync_sys_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int PTR_WIDTH = clog2(DEPTH)
) (
  input  logic                 dest_clk,
  input  logic                 dest_rst,
  input  logic                 in_valid,
  input  logic                 out_ready,
  input  logic                 ovf_clr,
  output logic                 push,
  output logic                 drop,
  output logic [PTR_WIDTH-1:0] wr_ptr,
  output logic [PTR_WIDTH-1:0] rd_ptr,
  output logic [PTR_WIDTH:0]   count,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overflow
);
  localparam int CNT_W = PTR_WIDTH + 1;

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic                 overflow_q, overflow_d;
  logic                 pop;
  logic                 full;

  // Handshake decode; a pop frees a slot so a full queue can still accept a word.
  always_comb begin
    full = (count_q == CNT_W'(DEPTH));
    pop  = (count_q != '0) & out_ready;
    push = in_valid & (~full | pop);
    drop = in_valid & ~push;
  end

  // Next pointers, occupancy and sticky overflow (a new drop beats a clear).
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_WIDTH'(push);
    rd_ptr_d   = rd_ptr_q + PTR_WIDTH'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d = overflow_q;
    if (ovf_clr) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  // State registers; asynchronous reset discards everything in flight.
  always_ff @(posedge dest_clk or negedge dest_rst) begin
    if (!dest_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Status outputs come straight from registers.
  always_comb begin
    wr_ptr    = wr_ptr_q;
    rd_ptr    = rd_ptr_q;
    count     = count_q;
    out_valid = (count_q != '0);
    busy      = full;
    overflow  = overflow_q;
  end

endmodule

// File: rtl/sync_word_buffer.sv
// Elastic FIFO behind the bus synchronizer: captures each strobed word, presents
// the head word first-word-fall-through, exports busy/overflow for throttling.
// Build option: SYNC_WORD_BUF_STATS_EN adds a saturating drop counter ovf_count.
module sync_word_buffer
  import sync_sys_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int PTR_WIDTH = clog2(DEPTH)
) (
  input  logic                  dest_clk,
  input  logic                  dest_rst,
  sync_word_buffer_if.slave     bus,
  output logic                  busy,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
`ifdef SYNC_WORD_BUF_STATS_EN
  output logic [OVF_CNT_W-1:0]  ovf_count,
`endif
  input  logic                  ovf_clr
);
  logic                 push;
  logic                 drop;
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 out_valid;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;

  sync_word_buf_ctrl #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_ctrl (
    .dest_clk  (dest_clk),
    .dest_rst  (dest_rst),
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .ovf_clr   (ovf_clr),
    .push      (push),
    .drop      (drop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .out_valid (out_valid),
    .busy      (busy),
    .overflow  (overflow)
  );

  // Write the incoming word into the tail slot on an accepted push.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = bus.in_data;
  end

  // Storage is reset so out_data reads zero after reset rather than stale data.
  always_ff @(posedge dest_clk or negedge dest_rst) begin
    if (!dest_rst) mem_q <= '0;
    else           mem_q <= mem_d;
  end

  // Head-of-queue presentation, registers only.
  always_comb begin
    bus.out_valid = out_valid;
    bus.out_data  = mem_q[rd_ptr];
  end

`ifdef SYNC_WORD_BUF_STATS_EN
  logic [OVF_CNT_W-1:0] ovf_count_q, ovf_count_d;

  // Saturating drop counter; a drop arriving with the clear leaves a count of one.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (drop) begin
      if (ovf_clr)                 ovf_count_d = OVF_CNT_W'(1);
      else if (ovf_count_q != '1)  ovf_count_d = ovf_count_q + OVF_CNT_W'(1);
    end else if (ovf_clr) begin
      ovf_count_d = '0;
    end
  end

  // Drop counter register.
  always_ff @(posedge dest_clk or negedge dest_rst) begin
    if (!dest_rst) ovf_count_q <= '0;
    else           ovf_count_q <= ovf_count_d;
  end

  assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_sync_word_buffer.sv
// Directed bench for sync_word_buffer (DATA_WIDTH=8, DEPTH=4).
module tb_sync_word_buffer;
  logic       dest_clk = 1'b0;
  logic       dest_rst = 1'b0;
  logic       busy;
  logic [2:0] count;
  logic       overflow;
  logic       ovf_clr = 1'b0;
`ifdef SYNC_WORD_BUF_STATS_EN
  logic [7:0] ovf_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sync_word_buffer_if #(.DATA_WIDTH(8)) bus ();

  sync_word_buffer #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .dest_clk  (dest_clk),
    .dest_rst  (dest_rst),
    .bus       (bus),
    .busy      (busy),
    .count     (count),
    .overflow  (overflow),
`ifdef SYNC_WORD_BUF_STATS_EN
    .ovf_count (ovf_count),
`endif
    .ovf_clr   (ovf_clr)
  );

  always #5 dest_clk = ~dest_clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs, then back to idle; returns 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic c);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    ovf_clr       = c;
    @(posedge dest_clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    ovf_clr       = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_word;
    int         npop;
    logic [7:0] exp_q [4];

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // reset state
    @(posedge dest_clk); #1;
    chk("rst_count", count, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
`ifdef SYNC_WORD_BUF_STATS_EN
    chk("rst_ovf_count", ovf_count, 0);
`endif
    dest_rst = 1'b1;

    // T2 basic push then pop
    cyc(1, 8'hA5, 0, 0);
    chk("t2_valid", bus.out_valid, 1);
    chk("t2_data", bus.out_data, 8'hA5);
    chk("t2_count1", count, 1);
    cyc(0, 8'h00, 1, 0);
    chk("t2_count0", count, 0);
    chk("t2_valid0", bus.out_valid, 0);
    cyc(0, 8'h00, 1, 0);
    chk("t2_ready_empty", count, 0);

    // T3 ordering across pointer wrap: push on even cycles, pop on odd cycles
    exp_word = 8'h01;
    npop = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        cyc(1, 8'(i / 2 + 1), 0, 0);
      end else begin
        chk("t3_valid", bus.out_valid, 1);
        chk("t3_order", bus.out_data, exp_word);
        exp_word = exp_word + 8'h01;
        npop++;
        cyc(0, 8'h00, 1, 0);
      end
    end
    chk("t3_pops", npop, 10);
    chk("t3_count", count, 0);
    chk("t3_no_ovf", overflow, 0);

    // T4 fill, drop, clear
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'h33, 0, 0);
    chk("t4_busy3", busy, 0);
    cyc(1, 8'h44, 0, 0);
    chk("t4_busy", busy, 1);
    chk("t4_count4", count, 4);
    cyc(1, 8'hEE, 0, 0);
    chk("t4_ovf", overflow, 1);
    chk("t4_count_drop", count, 4);
    chk("t4_head", bus.out_data, 8'h11);
    cyc(0, 8'h00, 0, 1);
    chk("t4_clr", overflow, 0);
    cyc(1, 8'hFF, 0, 1);
    chk("t4_set_wins", overflow, 1);
    cyc(0, 8'h00, 0, 1);
    chk("t4_clr2", overflow, 0);

    // T5 full with simultaneous push and pop
    chk("t5_head_pre", bus.out_data, 8'h11);
    cyc(1, 8'h77, 1, 0);
    chk("t5_count", count, 4);
    chk("t5_no_ovf", overflow, 0);
    chk("t5_busy", busy, 1);
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h77};
    for (int i = 0; i < 4; i++) begin
      chk("t5_drain", bus.out_data, exp_q[i]);
      cyc(0, 8'h00, 1, 0);
    end
    chk("t5_empty", count, 0);

    // T1 asynchronous reset mid-stream with count=3 and overflow set
    cyc(1, 8'h5A, 0, 0);
    cyc(1, 8'h6B, 0, 0);
    cyc(1, 8'h7C, 0, 0);
    cyc(1, 8'h8D, 0, 0);
    cyc(1, 8'h9E, 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("t1_pre_count", count, 3);
    chk("t1_pre_ovf", overflow, 1);
    #2 dest_rst = 1'b0;
    #1;
    chk("t1_count", count, 0);
    chk("t1_valid", bus.out_valid, 0);
    chk("t1_data", bus.out_data, 0);
    chk("t1_ovf", overflow, 0);
    @(negedge dest_clk);
    dest_rst = 1'b1;
    @(posedge dest_clk); #1;
    chk("t1_after", count, 0);

`ifdef SYNC_WORD_BUF_STATS_EN
    // T6 saturating drop counter
    for (int i = 0; i < 4; i++) cyc(1, 8'(i), 0, 0);
    for (int i = 0; i < 300; i++) cyc(1, 8'hC3, 0, 0);
    chk("t6_sat", ovf_count, 8'hFF);
    cyc(1, 8'hC3, 0, 1);
    chk("t6_clr_drop", ovf_count, 1);
    cyc(0, 8'h00, 0, 1);
    chk("t6_clr", ovf_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
